// File: rtl/tiny_pkg.sv
// Shared widths, the out-of-range fill word and the response record passed
// from the program memory read stage into its output buffer.
package tiny_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 16;
   localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = 16'h0000;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] instr;
      logic [DEF_ADDR_W-1:0] addr;
      logic                  err;
   } fetch_rsp_t;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry response FIFO with fall-through when empty, so a read result is
// visible the cycle it arrives; flush drops stored entries and the arrival.
module fetch_skid_fifo
   import tiny_pkg::*;
#(
   parameter type rsp_t = fetch_rsp_t
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   input  logic       in_valid,
   output logic       in_ready,
   input  rsp_t       in_data,
   output logic       out_valid,
   input  logic       out_ready,
   output rsp_t       out_data,
   output logic [1:0] count
);

   rsp_t entry [2];
   logic rd_ptr;
   logic wr_ptr;
   logic empty;
   logic bypass;
   logic push;
   logic pop;

   assign empty     = (count == 2'd0);
   assign in_ready  = (count != 2'd2);
   assign out_valid = ~empty | in_valid;
   assign out_data  = empty ? in_data : entry[rd_ptr];

   // An arrival consumed straight through never occupies a slot.
   assign bypass = empty & in_valid & out_ready;
   assign push   = in_valid & in_ready & ~bypass & ~flush;
   assign pop    = ~empty & out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk) begin
      if (push) entry[wr_ptr] <= in_data;
   end

endmodule

// File: rtl/prog_mem_fetch.sv
// Program memory with a valid/ready fetch port, registered 1-cycle read,
// credit-limited 2-entry response buffer, branch flush and a load port.
module prog_mem_fetch
   import tiny_pkg::*;
#(
   parameter int                DATA_W    = DEF_DATA_W,
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                DEPTH     = 65536,
   parameter logic [DATA_W-1:0] NOP_WORD  = DATA_W'(DEF_NOP_WORD),
   parameter string             INIT_FILE = ""
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_valid,
   output logic              fetch_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_instr,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_err,
   input  logic              flush,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [DATA_W-1:0] load_data
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

   typedef struct packed {
      logic [DATA_W-1:0] instr;
      logic [ADDR_W-1:0] addr;
      logic              err;
   } rsp_t;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              fetch_acc;
   logic              fetch_in_range;
   logic              load_in_range;
   logic [1:0]        pending;
   logic [1:0]        fifo_cnt;
   logic              fifo_in_ready;
   logic              vld_p1;
   logic [DATA_W-1:0] instr_p1;
   logic [ADDR_W-1:0] addr_p1;
   logic              err_p1;
   rsp_t              rsp_p1;
   rsp_t              rsp_out;

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = NOP_WORD;
   end

   assign fetch_in_range = ({1'b0, fetch_addr} < DEPTH_LIM);
   assign load_in_range  = ({1'b0, load_addr} < DEPTH_LIM);

   // Reads in flight plus buffered entries never exceed the two buffer slots.
   assign pending     = {1'b0, vld_p1} + fifo_cnt;
   assign fetch_ready = rst_n & ~load_en & fifo_in_ready & (pending < 2'd2);
   assign fetch_acc   = fetch_valid & fetch_ready;

   always @(posedge clk) begin
      if (load_en && load_in_range) mem[load_addr[IDX_W-1:0]] <= load_data;
   end

   // Stage p0 -> p1: registered array read or out-of-range fill.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         instr_p1 <= '0;
         addr_p1  <= '0;
         err_p1   <= 1'b0;
      end else begin
         vld_p1 <= fetch_acc;
         if (fetch_acc) begin
            addr_p1  <= fetch_addr;
            err_p1   <= ~fetch_in_range;
            instr_p1 <= fetch_in_range ? mem[fetch_addr[IDX_W-1:0]] : NOP_WORD;
         end
      end
   end

   assign rsp_p1 = '{instr: instr_p1, addr: addr_p1, err: err_p1};

   // Stage p1 -> output: response buffer.
   fetch_skid_fifo #(
      .rsp_t (rsp_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (vld_p1),
      .in_ready  (fifo_in_ready),
      .in_data   (rsp_p1),
      .out_valid (rsp_valid),
      .out_ready (rsp_ready),
      .out_data  (rsp_out),
      .count     (fifo_cnt)
   );

   assign rsp_instr = rsp_out.instr;
   assign rsp_addr  = rsp_out.addr;
   assign rsp_err   = rsp_out.err;

endmodule

// File: tb/tb_prog_mem_fetch.sv
// Bench for prog_mem_fetch (DEPTH=256): directed scenarios then random traffic
// against a queue-of-pending-responses reference model.
module tb_prog_mem_fetch;

   localparam int          DEPTH = 256;
   localparam logic [15:0] NOP   = 16'h0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_valid;
   logic        fetch_ready;
   logic [15:0] fetch_addr;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_instr;
   logic [15:0] rsp_addr;
   logic        rsp_err;
   logic        flush;
   logic        load_en;
   logic [15:0] load_addr;
   logic [15:0] load_data;

   always #5 clk = ~clk;

   prog_mem_fetch #(
      .DATA_W    (16),
      .ADDR_W    (16),
      .DEPTH     (DEPTH),
      .NOP_WORD  (NOP),
      .INIT_FILE ("")
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fetch_valid (fetch_valid),
      .fetch_ready (fetch_ready),
      .fetch_addr  (fetch_addr),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_instr   (rsp_instr),
      .rsp_addr    (rsp_addr),
      .rsp_err     (rsp_err),
      .flush       (flush),
      .load_en     (load_en),
      .load_addr   (load_addr),
      .load_data   (load_data)
   );

   typedef struct {
      logic [15:0] instr;
      logic [15:0] addr;
      logic        err;
   } exp_t;

   exp_t        q[$];
   logic [15:0] mem_m [DEPTH];
   int          n_tests = 0;
   int          n_fail  = 0;
   bit          last_acc;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive(bit fv, logic [15:0] fa, bit rr, bit fl,
                        bit le, logic [15:0] la, logic [15:0] ld);
      fetch_valid = fv;
      fetch_addr  = fa;
      rsp_ready   = rr;
      flush       = fl;
      load_en     = le;
      load_addr   = la;
      load_data   = ld;
   endtask

   // One clock: inputs are already applied just after a negedge.
   task automatic tick();
      bit   exp_ready;
      bit   pop;
      exp_t e;
      exp_ready = rst_n && !load_en && (q.size() < 2);
      #1;
      chk("fetch_ready", fetch_ready, exp_ready);
      last_acc = fetch_valid && exp_ready;
      pop      = (q.size() != 0) && rsp_ready;
      @(posedge clk);
      if (!rst_n) begin
         q.delete();
      end else begin
         if (pop) void'(q.pop_front());
         if (flush) q.delete();
         if (last_acc) begin
            e.addr  = fetch_addr;
            e.err   = (fetch_addr >= DEPTH);
            e.instr = e.err ? NOP : mem_m[fetch_addr[7:0]];
            q.push_back(e);
         end
      end
      if (load_en && load_addr < DEPTH) mem_m[load_addr[7:0]] = load_data;
      @(negedge clk);
      chk("rsp_valid", rsp_valid, q.size() != 0);
      if (q.size() != 0) begin
         chk("rsp_instr", rsp_instr, q[0].instr);
         chk("rsp_addr", rsp_addr, q[0].addr);
         chk("rsp_err", rsp_err, q[0].err);
      end
   endtask

   task automatic fetch_until(logic [15:0] a);
      bit done = 0;
      for (int k = 0; k < 20 && !done; k++) begin
         drive(1, a, 1, 0, 0, 0, 0);
         tick();
         done = last_acc;
      end
      if (!done) chk("accept_timeout", 0, 1);
   endtask

   task automatic idle(int n);
      drive(0, 0, 1, 0, 0, 0, 0);
      repeat (n) tick();
   endtask

   initial begin
      logic [15:0] prog [4];
      prog[0] = 16'h6105;
      prog[1] = 16'h6203;
      prog[2] = 16'h1300;
      prog[3] = 16'hF000;
      for (int i = 0; i < DEPTH; i++) mem_m[i] = NOP;

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("reset_valid", rsp_valid, 0);
      chk("reset_instr", rsp_instr, 0);
      chk("reset_addr", rsp_addr, 0);
      chk("reset_err", rsp_err, 0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 0, 1, 16'(i), prog[i]);
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 16'(i), 1, 0, 0, 0, 0);
         tick();
         chk("b2b_accept", last_acc, 1);
         chk("b2b_addr", rsp_addr, 16'(i));
         chk("b2b_instr", rsp_instr, prog[i]);
      end
      idle(3);

      drive(1, 0, 0, 0, 0, 0, 0); tick(); chk("bp_acc0", last_acc, 1);
      drive(1, 1, 0, 0, 0, 0, 0); tick(); chk("bp_acc1", last_acc, 1);
      drive(1, 2, 0, 0, 0, 0, 0); tick(); chk("bp_block", last_acc, 0);
      tick(); chk("bp_block2", last_acc, 0);
      chk("bp_head", rsp_addr, 0);
      fetch_until(2);
      idle(4);

      fetch_until(16'h0100);
      chk("oor_instr", rsp_instr, NOP);
      chk("oor_err", rsp_err, 1);
      drive(0, 0, 1, 0, 1, 16'h0100, 16'hBEEF); tick();
      fetch_until(16'h0100);
      chk("oor_load_ignored", rsp_instr, NOP);
      fetch_until(16'h00FF);
      chk("last_word_err", rsp_err, 0);
      idle(2);

      drive(1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 0, 0, 0, 0); tick();
      drive(1, 3, 0, 1, 0, 0, 0); tick();
      fetch_until(3);
      chk("flush_next_addr", rsp_addr, 3);
      chk("flush_next_instr", rsp_instr, 16'hF000);
      idle(2);
      drive(1, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 3, 0, 1, 0, 0, 0); tick();
      chk("flush_keep_acc", last_acc, 1);
      chk("flush_keep_addr", rsp_addr, 3);
      idle(2);

      drive(1, 2, 1, 0, 1, 2, 16'hAAAA); tick();
      chk("load_blocks_fetch", last_acc, 0);
      fetch_until(2);
      chk("after_load_instr", rsp_instr, 16'hAAAA);
      idle(2);

      drive(1, 1, 0, 0, 0, 0, 0); tick();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0); tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_valid", rsp_valid, 0);
      fetch_until(1);
      chk("array_kept", rsp_instr, prog[1]);
      idle(2);

      for (int c = 0; c < 2000; c++) begin
         rst_n = ($urandom_range(99) != 0);
         drive($urandom_range(9) < 7, 16'($urandom_range(16'h013F)),
               $urandom_range(9) < 7, $urandom_range(19) == 0,
               $urandom_range(99) < 8, 16'($urandom_range(16'h013F)),
               16'($urandom));
         tick();
      end
      rst_n = 1'b1;
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
